// File: rtl/control_sequencer_if.sv
// Signal bundle between the control sequencer and the Bat Amateur datapath.
// The master side is the sequencer: it reads the instruction word and flags and drives the strobes.
interface control_sequencer_if #(
  parameter int BUS_WIDTH = 16
);
  logic                 RUN;
  logic [BUS_WIDTH-1:0] INSTRUCTION;
  logic                 CARRY_FLAG;
  logic                 ZERO_FLAG;

  logic PC_ENABLE, PC_COUNT, PC_LOAD;
  logic MAR_LOAD;
  logic RAM_ENABLE, RAM_LOAD;
  logic IR_LOAD, IR_ENABLE;
  logic A_LOAD, A_ENABLE, B_LOAD;
  logic ALU_ENABLE, ALU_SUB, FLAG_LOAD;
  logic OUT_LOAD;
  logic HALT;
  logic [2:0] T_STATE;

  modport master (
    input  RUN, INSTRUCTION, CARRY_FLAG, ZERO_FLAG,
    output PC_ENABLE, PC_COUNT, PC_LOAD, MAR_LOAD, RAM_ENABLE, RAM_LOAD,
           IR_LOAD, IR_ENABLE, A_LOAD, A_ENABLE, B_LOAD,
           ALU_ENABLE, ALU_SUB, FLAG_LOAD, OUT_LOAD, HALT, T_STATE
  );

  modport slave (
    output RUN, INSTRUCTION, CARRY_FLAG, ZERO_FLAG,
    input  PC_ENABLE, PC_COUNT, PC_LOAD, MAR_LOAD, RAM_ENABLE, RAM_LOAD,
           IR_LOAD, IR_ENABLE, A_LOAD, A_ENABLE, B_LOAD,
           ALU_ENABLE, ALU_SUB, FLAG_LOAD, OUT_LOAD, HALT, T_STATE
  );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded control unit: fetch/execute step counter, halt state and the
// per-micro-step datapath strobes decoded from the opcode in the top 4 instruction bits.
module control_sequencer #(
  parameter int BUS_WIDTH = 16
) (
  input  logic                CLOCK,
  input  logic                RESET,
  control_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  step_e      t_q, t_d;
  logic       halted_q, halted_d;
  logic [3:0] opcode;
  step_e      final_step;
  logic       active;

  assign opcode = bus.INSTRUCTION[BUS_WIDTH-1 -: 4];

  // Strobes only fire when running, not halted, and outside reset so that an
  // asserted reset silences the datapath without waiting for a clock.
  assign active = RESET && bus.RUN && !halted_q;

  always_comb begin
    final_step = T2;
    case (opcode)
      OP_LDA, OP_STA: final_step = T3;
      OP_ADD, OP_SUB: final_step = T4;
      default:        final_step = T2;
    endcase
  end

  // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    t_d      = t_q;
    halted_d = halted_q;
    if (bus.RUN && !halted_q) begin
      // ">=" also recovers cleanly if the IR changes underneath a longer instruction.
      if (t_q >= final_step) t_d = T0;
      else                   t_d = step_e'(t_q + 3'd1);
      if (t_q == T2 && opcode == OP_HLT) halted_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      t_q      <= T0;
      halted_q <= 1'b0;
    end else begin
      t_q      <= t_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    bus.PC_ENABLE  = 1'b0;
    bus.PC_COUNT   = 1'b0;
    bus.PC_LOAD    = 1'b0;
    bus.MAR_LOAD   = 1'b0;
    bus.RAM_ENABLE = 1'b0;
    bus.RAM_LOAD   = 1'b0;
    bus.IR_LOAD    = 1'b0;
    bus.IR_ENABLE  = 1'b0;
    bus.A_LOAD     = 1'b0;
    bus.A_ENABLE   = 1'b0;
    bus.B_LOAD     = 1'b0;
    bus.ALU_ENABLE = 1'b0;
    bus.ALU_SUB    = 1'b0;
    bus.FLAG_LOAD  = 1'b0;
    bus.OUT_LOAD   = 1'b0;
    if (active) begin
      case (t_q)
        T0: begin
          bus.PC_ENABLE = 1'b1;
          bus.MAR_LOAD  = 1'b1;
        end
        T1: begin
          bus.RAM_ENABLE = 1'b1;
          bus.IR_LOAD    = 1'b1;
          bus.PC_COUNT   = 1'b1;
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              bus.IR_ENABLE = 1'b1;
              bus.MAR_LOAD  = 1'b1;
            end
            OP_LDI: begin
              bus.IR_ENABLE = 1'b1;
              bus.A_LOAD    = 1'b1;
            end
            OP_JMP: begin
              bus.IR_ENABLE = 1'b1;
              bus.PC_LOAD   = 1'b1;
            end
            OP_JC: begin
              bus.IR_ENABLE = 1'b1;
              bus.PC_LOAD   = bus.CARRY_FLAG;
            end
            OP_JZ: begin
              bus.IR_ENABLE = 1'b1;
              bus.PC_LOAD   = bus.ZERO_FLAG;
            end
            OP_OUT: begin
              bus.A_ENABLE = 1'b1;
              bus.OUT_LOAD = 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin
              bus.RAM_ENABLE = 1'b1;
              bus.A_LOAD     = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              bus.RAM_ENABLE = 1'b1;
              bus.B_LOAD     = 1'b1;
            end
            OP_STA: begin
              bus.A_ENABLE = 1'b1;
              bus.RAM_LOAD = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            bus.ALU_ENABLE = 1'b1;
            bus.A_LOAD     = 1'b1;
            bus.FLAG_LOAD  = 1'b1;
            bus.ALU_SUB    = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.HALT    = halted_q;
  assign bus.T_STATE = t_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a table of per-cycle vectors plus
// hand-written sequences for RUN gating, halt, and asynchronous reset mid-instruction.
module tb_control_sequencer;

  localparam logic [14:0] S_PCE  = 15'h4000;
  localparam logic [14:0] S_PCC  = 15'h2000;
  localparam logic [14:0] S_PCL  = 15'h1000;
  localparam logic [14:0] S_MAR  = 15'h0800;
  localparam logic [14:0] S_RAME = 15'h0400;
  localparam logic [14:0] S_RAML = 15'h0200;
  localparam logic [14:0] S_IRL  = 15'h0100;
  localparam logic [14:0] S_IRE  = 15'h0080;
  localparam logic [14:0] S_AL   = 15'h0040;
  localparam logic [14:0] S_AE   = 15'h0020;
  localparam logic [14:0] S_BL   = 15'h0010;
  localparam logic [14:0] S_ALUE = 15'h0008;
  localparam logic [14:0] S_SUB  = 15'h0004;
  localparam logic [14:0] S_FL   = 15'h0002;
  localparam logic [14:0] S_OUT  = 15'h0001;
  localparam logic [14:0] S_NONE = 15'h0000;
  localparam logic [14:0] F_T0   = S_PCE | S_MAR;
  localparam logic [14:0] F_T1   = S_RAME | S_IRL | S_PCC;

  typedef struct {
    logic [15:0] instr;
    logic        cf;
    logic        zf;
    logic        run;
    logic [14:0] exp;
    logic [2:0]  t;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  control_sequencer_if #(.BUS_WIDTH(16)) bus ();

  control_sequencer #(.BUS_WIDTH(16)) dut (
    .CLOCK (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [14:0] get_strobes();
    return {bus.PC_ENABLE, bus.PC_COUNT, bus.PC_LOAD, bus.MAR_LOAD,
            bus.RAM_ENABLE, bus.RAM_LOAD, bus.IR_LOAD, bus.IR_ENABLE,
            bus.A_LOAD, bus.A_ENABLE, bus.B_LOAD, bus.ALU_ENABLE,
            bus.ALU_SUB, bus.FLAG_LOAD, bus.OUT_LOAD};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name, input logic [14:0] exp,
                               input logic halt, input logic [2:0] t);
    int n_enables;
    n_enables = int'(bus.PC_ENABLE) + int'(bus.RAM_ENABLE) + int'(bus.IR_ENABLE)
              + int'(bus.A_ENABLE) + int'(bus.ALU_ENABLE);
    check({name, " strobes"}, 32'(get_strobes()), 32'(exp));
    check({name, " t_state"}, 32'(bus.T_STATE), 32'(t));
    check({name, " halt"}, 32'(bus.HALT), 32'(halt));
    check({name, " bus_excl"}, 32'(n_enables <= 1), 32'd1);
  endtask

  // Entered just after a rising edge: drive, sample mid-cycle, advance one clock.
  task automatic step(input string name, input logic [15:0] instr, input logic cf,
                      input logic zf, input logic run, input logic [14:0] exp,
                      input logic halt, input logic [2:0] t);
    bus.INSTRUCTION = instr;
    bus.CARRY_FLAG  = cf;
    bus.ZERO_FLAG   = zf;
    bus.RUN         = run;
    @(negedge clk);
    check_outputs(name, exp, halt, t);
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [15:0] instr, input logic cf, input logic zf,
                         input logic [14:0] exp, input logic [2:0] t);
    vec_t v;
    v.instr = instr;
    v.cf    = cf;
    v.zf    = zf;
    v.run   = 1'b1;
    v.exp   = exp;
    v.t     = t;
    vecs.push_back(v);
  endtask

  task automatic add_instr(input logic [15:0] instr, input logic cf, input logic zf,
                           input int n_steps, input logic [14:0] e2,
                           input logic [14:0] e3, input logic [14:0] e4);
    add_vec(instr, cf, zf, F_T0, 3'd0);
    add_vec(instr, cf, zf, F_T1, 3'd1);
    add_vec(instr, cf, zf, e2, 3'd2);
    if (n_steps > 3) add_vec(instr, cf, zf, e3, 3'd3);
    if (n_steps > 4) add_vec(instr, cf, zf, e4, 3'd4);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.RUN         = 1'b1;
    bus.INSTRUCTION = 16'h0000;
    bus.CARRY_FLAG  = 1'b0;
    bus.ZERO_FLAG   = 1'b0;

    // Held in reset with RUN high: T0 would normally strobe, reset must hold everything low.
    repeat (2) @(posedge clk);
    #1;
    check_outputs("in_reset", S_NONE, 1'b0, 3'd0);

    add_instr(16'h0000, 1'b0, 1'b0, 3, S_NONE, S_NONE, S_NONE);
    add_instr(16'h200F, 1'b0, 1'b0, 5, S_IRE | S_MAR, S_RAME | S_BL, S_ALUE | S_AL | S_FL);
    add_instr(16'h300F, 1'b0, 1'b0, 5, S_IRE | S_MAR, S_RAME | S_BL,
              S_ALUE | S_AL | S_FL | S_SUB);
    add_instr(16'h7123, 1'b0, 1'b0, 3, S_IRE, S_NONE, S_NONE);
    add_instr(16'h7123, 1'b1, 1'b0, 3, S_IRE | S_PCL, S_NONE, S_NONE);
    add_instr(16'h7123, 1'b0, 1'b1, 3, S_IRE, S_NONE, S_NONE);
    add_instr(16'h8123, 1'b0, 1'b0, 3, S_IRE, S_NONE, S_NONE);
    add_instr(16'h8123, 1'b0, 1'b1, 3, S_IRE | S_PCL, S_NONE, S_NONE);
    add_instr(16'h8123, 1'b1, 1'b0, 3, S_IRE, S_NONE, S_NONE);
    add_instr(16'h5042, 1'b0, 1'b0, 3, S_IRE | S_AL, S_NONE, S_NONE);
    add_instr(16'h6ABC, 1'b0, 1'b0, 3, S_IRE | S_PCL, S_NONE, S_NONE);
    add_instr(16'hE000, 1'b0, 1'b0, 3, S_AE | S_OUT, S_NONE, S_NONE);
    add_instr(16'hA000, 1'b0, 1'b0, 3, S_NONE, S_NONE, S_NONE);
    add_instr(16'hD555, 1'b0, 1'b0, 3, S_NONE, S_NONE, S_NONE);
    add_instr(16'h1010, 1'b0, 1'b0, 4, S_IRE | S_MAR, S_RAME | S_AL, S_NONE);
    add_instr(16'h4020, 1'b0, 1'b0, 4, S_IRE | S_MAR, S_AE | S_RAML, S_NONE);

    // Release just after an edge so the whole following half-cycle shows T0.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i].instr, vecs[i].cf, vecs[i].zf,
           vecs[i].run, vecs[i].exp, 1'b0, vecs[i].t);
    end

    // RUN dropped for three cycles during LDA T3.
    step("lda_t0", 16'h1000, 1'b0, 1'b0, 1'b1, F_T0, 1'b0, 3'd0);
    step("lda_t1", 16'h1000, 1'b0, 1'b0, 1'b1, F_T1, 1'b0, 3'd1);
    step("lda_t2", 16'h1000, 1'b0, 1'b0, 1'b1, S_IRE | S_MAR, 1'b0, 3'd2);
    for (int k = 0; k < 3; k++)
      step($sformatf("run_low%0d", k), 16'h1000, 1'b0, 1'b0, 1'b0, S_NONE, 1'b0, 3'd3);
    step("lda_t3_resume", 16'h1000, 1'b0, 1'b0, 1'b1, S_RAME | S_AL, 1'b0, 3'd3);
    step("after_lda_t0", 16'h0000, 1'b0, 1'b0, 1'b1, F_T0, 1'b0, 3'd0);
    step("after_lda_t1", 16'h0000, 1'b0, 1'b0, 1'b1, F_T1, 1'b0, 3'd1);
    step("after_lda_t2", 16'h0000, 1'b0, 1'b0, 1'b1, S_NONE, 1'b0, 3'd2);

    // Asynchronous reset between edges during STA T3.
    step("sta_t0", 16'h4000, 1'b0, 1'b0, 1'b1, F_T0, 1'b0, 3'd0);
    step("sta_t1", 16'h4000, 1'b0, 1'b0, 1'b1, F_T1, 1'b0, 3'd1);
    step("sta_t2", 16'h4000, 1'b0, 1'b0, 1'b1, S_IRE | S_MAR, 1'b0, 3'd2);
    @(negedge clk);
    check_outputs("sta_t3", S_AE | S_RAML, 1'b0, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset", S_NONE, 1'b0, 3'd0);
    @(posedge clk);
    #1;
    check_outputs("reset_held", S_NONE, 1'b0, 3'd0);
    rst_n = 1'b1;
    step("post_reset_t0", 16'h0000, 1'b0, 1'b0, 1'b1, F_T0, 1'b0, 3'd0);
    step("post_reset_t1", 16'h0000, 1'b0, 1'b0, 1'b1, F_T1, 1'b0, 3'd1);
    step("post_reset_t2", 16'h0000, 1'b0, 1'b0, 1'b1, S_NONE, 1'b0, 3'd2);

    // HLT: halted from the edge closing T2, sticky until reset.
    step("hlt_t0", 16'hF000, 1'b0, 1'b0, 1'b1, F_T0, 1'b0, 3'd0);
    step("hlt_t1", 16'hF000, 1'b0, 1'b0, 1'b1, F_T1, 1'b0, 3'd1);
    step("hlt_t2", 16'hF000, 1'b0, 1'b0, 1'b1, S_NONE, 1'b0, 3'd2);
    for (int k = 0; k < 20; k++)
      step($sformatf("halted%0d", k), (k % 2 == 0) ? 16'h200F : 16'h0000,
           1'b1, 1'b1, 1'b1, S_NONE, 1'b1, 3'd0);
    rst_n = 1'b0;
    #1;
    check_outputs("halt_reset", S_NONE, 1'b0, 3'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("unhalt_t0", 16'h0000, 1'b0, 1'b0, 1'b1, F_T0, 1'b0, 3'd0);
    step("unhalt_t1", 16'h0000, 1'b0, 1'b0, 1'b1, F_T1, 1'b0, 3'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
